// File: rtl/bus_pkg.sv
// Shared bus codes, sizes and FSM state encoding for the register-transfer controller.
package bus_pkg;

    localparam int unsigned CODE_W = 5;
    localparam int unsigned SRC_N  = 24;
    localparam int unsigned DST_N  = 25;

    // Sources: R0..R15 occupy codes 0..15
    localparam logic [CODE_W-1:0] SRC_R0     = 5'd0;
    localparam logic [CODE_W-1:0] SRC_R15    = 5'd15;
    localparam logic [CODE_W-1:0] SRC_MDR    = 5'd16;
    localparam logic [CODE_W-1:0] SRC_HI     = 5'd17;
    localparam logic [CODE_W-1:0] SRC_LO     = 5'd18;
    localparam logic [CODE_W-1:0] SRC_ZHIGH  = 5'd19;
    localparam logic [CODE_W-1:0] SRC_ZLOW   = 5'd20;
    localparam logic [CODE_W-1:0] SRC_PC     = 5'd21;
    localparam logic [CODE_W-1:0] SRC_INPORT = 5'd22;
    localparam logic [CODE_W-1:0] SRC_C      = 5'd23;

    // Destinations: R0..R15 occupy codes 0..15
    localparam logic [CODE_W-1:0] DST_R0      = 5'd0;
    localparam logic [CODE_W-1:0] DST_R15     = 5'd15;
    localparam logic [CODE_W-1:0] DST_HI      = 5'd16;
    localparam logic [CODE_W-1:0] DST_LO      = 5'd17;
    localparam logic [CODE_W-1:0] DST_Y       = 5'd18;
    localparam logic [CODE_W-1:0] DST_Z       = 5'd19;
    localparam logic [CODE_W-1:0] DST_PC      = 5'd20;
    localparam logic [CODE_W-1:0] DST_IR      = 5'd21;
    localparam logic [CODE_W-1:0] DST_MAR     = 5'd22;
    localparam logic [CODE_W-1:0] DST_MDR     = 5'd23;
    localparam logic [CODE_W-1:0] DST_OUTPORT = 5'd24;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        LATCH
    } xfer_state_t;

endpackage

// File: rtl/xfer_fifo.sv
// Small power-of-two request FIFO; pointers wrap naturally, count is one bit wider.
module xfer_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Register-transfer bus sequencer: one-hot source drive, then destination load strobe.
// Define XFER_QUEUE_EN to buffer requests in a QDEPTH-entry FIFO instead of a capture register.
module bus_xfer_ctrl
    import bus_pkg::*;
#(
    parameter int unsigned SRC_N  = bus_pkg::SRC_N,
    parameter int unsigned DST_N  = bus_pkg::DST_N,
    parameter int unsigned QDEPTH = 4
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              req_valid,
    input  logic [CODE_W-1:0] req_src,
    input  logic [CODE_W-1:0] req_dst,
    output logic              req_ready,
    output logic [SRC_N-1:0]  src_out,
    output logic [DST_N-1:0]  dst_in,
    output logic              done,
    output logic              err
);

    localparam logic [CODE_W:0]  SRC_LIM = SRC_N[CODE_W:0];
    localparam logic [CODE_W:0]  DST_LIM = DST_N[CODE_W:0];
    localparam logic [SRC_N-1:0] SRC_ONE = {{(SRC_N-1){1'b0}}, 1'b1};
    localparam logic [DST_N-1:0] DST_ONE = {{(DST_N-1){1'b0}}, 1'b1};

    if ((QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
        $error("QDEPTH must be a power of 2");
    end

    xfer_state_t       state, state_next;
    logic [CODE_W-1:0] cur_src, cur_dst;
    logic [CODE_W-1:0] start_src, start_dst;
    logic [SRC_N-1:0]  src_next;
    logic [DST_N-1:0]  dst_next;
    logic              done_next;
    logic              ready_q;
    logic              take, code_ok, start;

    assign take    = req_valid && req_ready;
    assign code_ok = ({1'b0, req_src} < SRC_LIM) && ({1'b0, req_dst} < DST_LIM);

`ifdef XFER_QUEUE_EN
    logic                  q_full, q_empty, push, pop;
    logic [2*CODE_W-1:0]   q_head;

    // Invalid codes are rejected at the door so the queue only holds executable work
    assign req_ready = ready_q && !q_full;
    assign push      = take && code_ok;
    assign pop       = (state != DRIVE) && !q_empty;
    assign start     = pop;
    assign start_src = q_head[2*CODE_W-1:CODE_W];
    assign start_dst = q_head[CODE_W-1:0];

    xfer_fifo #(
        .WIDTH (2*CODE_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clock (clock),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   ({req_src, req_dst}),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty)
    );
`else
    assign req_ready = ready_q && (state != DRIVE);
    assign start     = take && code_ok;
    assign start_src = req_src;
    assign start_dst = req_dst;
`endif

    always_comb begin
        state_next = state;
        src_next   = '0;
        dst_next   = '0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = DRIVE;
                    src_next   = SRC_ONE << start_src;
                end
            end
            DRIVE: begin
                state_next = LATCH;
                src_next   = SRC_ONE << cur_src;
                dst_next   = DST_ONE << cur_dst;
                done_next  = 1'b1;
            end
            LATCH: begin
                if (start) begin
                    state_next = DRIVE;
                    src_next   = SRC_ONE << start_src;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            src_out <= '0;
            dst_in  <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            ready_q <= 1'b0;
            cur_src <= '0;
            cur_dst <= '0;
        end else begin
            src_out <= src_next;
            dst_in  <= dst_next;
            done    <= done_next;
            err     <= take && !code_ok;
            ready_q <= 1'b1;
            if (start) begin
                cur_src <= start_src;
                cur_dst <= start_dst;
            end
        end
    end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Scoreboard bench for bus_xfer_ctrl: expected transfers and error pulses are queued at acceptance.
module tb_bus_xfer_ctrl;

    typedef struct {
        int cyc;
        int src;
        int dst;
    } xfer_t;

`ifdef XFER_QUEUE_EN
    localparam bit QMODE = 1'b1;
`else
    localparam bit QMODE = 1'b0;
`endif

    logic        clock;
    logic        clear;
    logic        req_valid;
    logic [4:0]  req_src;
    logic [4:0]  req_dst;
    logic        req_ready;
    logic [23:0] src_out;
    logic [24:0] dst_in;
    logic        done;
    logic        err;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    exp_done = 0;
    int    done_seen = 0;
    xfer_t xfer_q[$];
    int    err_q[$];
    logic [23:0] prev_src = '0;

    bus_xfer_ctrl #(
        .SRC_N  (24),
        .DST_N  (25),
        .QDEPTH (4)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .req_valid (req_valid),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .req_ready (req_ready),
        .src_out   (src_out),
        .dst_in    (dst_in),
        .done      (done),
        .err       (err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic logic [63:0] bit_at(input int n);
        logic [63:0] v;
        v = '0;
        if (n >= 0 && n < 64) v[n] = 1'b1;
        return v;
    endfunction

    always @(negedge clock) begin : monitor
        xfer_t e;
        logic  exp_err;
        check_eq("src_onehot0", 64'($onehot0(src_out)), 64'd1);
        check_eq("dst_onehot0", 64'($onehot0(dst_in)), 64'd1);
        exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
        check_eq("err", 64'(err), 64'(exp_err));
        if (exp_err) void'(err_q.pop_front());
        if (done) done_seen++;
        if (dst_in != '0 || (xfer_q.size() > 0 && xfer_q[0].cyc == cyc)) begin
            if (xfer_q.size() == 0) begin
                check_eq("unexpected_dst", 64'(dst_in), 64'd0);
            end else begin
                e = xfer_q.pop_front();
                if (e.cyc >= 0) check_eq("latch_cycle", 64'(cyc), 64'(e.cyc));
                check_eq("dst_in", 64'(dst_in), bit_at(e.dst));
                check_eq("src_latch", 64'(src_out), bit_at(e.src));
                check_eq("src_drive", 64'(prev_src), bit_at(e.src));
                check_eq("done", 64'(done), 64'd1);
            end
        end else begin
            check_eq("done_idle", 64'(done), 64'd0);
            if (src_out != '0)
                check_eq("src_drive_next", 64'(src_out),
                         (xfer_q.size() > 0) ? bit_at(xfer_q[0].src) : 64'd0);
        end
        prev_src = src_out;
    end

    // Holds the request until a ready edge accepts it, then records what must follow
    task automatic send(input int s, input int d);
        bit acc;
        int budget;
        xfer_t e;
        acc = 1'b0;
        budget = 0;
        req_valid = 1'b1;
        req_src = 5'(s);
        req_dst = 5'(d);
        while (!acc && budget < 50) begin
            acc = req_ready;
            @(posedge clock);
            #1;
            budget++;
        end
        if (!acc) begin
            check_eq("accept_timeout", 64'd0, 64'd1);
        end else if (s < 24 && d < 25) begin
            e.cyc = QMODE ? -1 : cyc + 1;
            e.src = s;
            e.dst = d;
            xfer_q.push_back(e);
            exp_done++;
        end else begin
            err_q.push_back(cyc);
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((xfer_q.size() != 0 || err_q.size() != 0) && n < 60) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (xfer_q.size() != 0 || err_q.size() != 0)
            check_eq("drain_timeout", 64'(xfer_q.size() + err_q.size()), 64'd0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        clear = 1'b0;
        req_valid = 1'b0;
        req_src = '0;
        req_dst = '0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_src_out", 64'(src_out), 64'd0);
        check_eq("rst_dst_in", 64'(dst_in), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        clear = 1'b1;
        #1;
        check_eq("ready_before_edge", 64'(req_ready), 64'd0);
        @(posedge clock);
        #1;
        check_eq("ready_after_edge", 64'(req_ready), 64'd1);

        send(5, 20);
        idle();
        drain();

        send(16, 21);
        send(20, 3);
        idle();
        drain();

        send(27, 2);
        check_eq("ready_after_err", 64'(req_ready), 64'd1);
        idle();
        drain();

        send(23, 24);
        send(16, 23);
        send(24, 0);
        send(0, 25);
        send(31, 31);
        send(15, 15);
        idle();
        drain();

        send(1, 18);
        idle();
        n = 0;
        while (src_out == '0 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_eq("drive_seen", 64'(src_out), bit_at(1));
        clear = 1'b0;
        #1;
        check_eq("clr_src_out", 64'(src_out), 64'd0);
        check_eq("clr_dst_in", 64'(dst_in), 64'd0);
        exp_done -= xfer_q.size();
        xfer_q.delete();
        repeat (3) @(posedge clock);
        #1;
        check_eq("clr_ready", 64'(req_ready), 64'd0);
        clear = 1'b1;
        @(posedge clock);
        #1;
        send(1, 18);
        idle();
        drain();

        repeat (10) send(int'($urandom_range(0, 26)), int'($urandom_range(0, 26)));
        idle();
        drain();

`ifdef XFER_QUEUE_EN
        for (int i = 0; i < 5; i++) send(i, 24 - i);
        idle();
        drain();
`endif

        check_eq("done_count", 64'(done_seen), 64'(exp_done));
        check_eq("xfer_q_empty", 64'(xfer_q.size()), 64'd0);
        check_eq("err_q_empty", 64'(err_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
